// File: rtl/wired0_pkg.sv
// Shared types for the wiredleg divider control slice: the operation encoding,
// the controller state set and a couple of operand helpers.
package wired0_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_MOD  = 2'd1,
    OP_DIVU = 2'd2,
    OP_MODU = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Bit 0 of the encoding selects remainder, bit 1 selects unsigned.
  function automatic logic op_is_rem(input op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return !op[1];
  endfunction

endpackage

// File: rtl/wiredleg_div_fast.sv
// Iterative radix-4 divider: operands are made positive on start, two restoring
// steps run per cycle for 16 cycles, and signs are reapplied on the outputs.
module wiredleg_div_fast
  import wired0_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_sign,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_quo,
  output logic [DATA_W-1:0] o_rem
);

  logic              r_busy;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic              r_neg_q;
  logic              r_neg_r;

  logic [2*DATA_W-1:0] w_s1;
  logic [2*DATA_W-1:0] w_s2;
  logic                w_neg_a;
  logic                w_neg_b;

  // One restoring step; the partial remainder is always below the divisor, so the
  // 32-bit subtraction is exact once the shifted-out bit joins the compare.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                  input logic [DATA_W-1:0] quo,
                                                  input logic [DATA_W-1:0] d);
    logic [DATA_W:0]   r;
    logic              ge;
    logic [DATA_W-1:0] nr;
    r  = {rem, quo[DATA_W-1]};
    ge = r[DATA_W] || (r[DATA_W-1:0] >= d);
    nr = ge ? (r[DATA_W-1:0] - d) : r[DATA_W-1:0];
    return {nr, quo[DATA_W-2:0], ge};
  endfunction

  assign w_s1    = div_step(r_rem, r_quo, r_div);
  assign w_s2    = div_step(w_s1[2*DATA_W-1:DATA_W], w_s1[DATA_W-1:0], r_div);
  assign w_neg_a = i_sign && i_a[DATA_W-1];
  assign w_neg_b = i_sign && i_b[DATA_W-1];

  // NOTE: the datapath registers are reset along with the control bits so the
  // result ports read zero after reset instead of carrying stale operands.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_neg_a ? -i_a : i_a;
      r_div   <= w_neg_b ? -i_b : i_b;
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end else if (r_busy) begin
      r_rem <= w_s2[2*DATA_W-1:DATA_W];
      r_quo <= w_s2[DATA_W-1:0];
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_quo  = r_neg_q ? -r_quo : r_quo;
  assign o_rem  = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/wiredleg_div_ctrl.sv
// Single-operation divide/modulo controller wrapping wiredleg_div_fast: accepts one
// tagged op, bypasses divide-by-zero, holds the result until consumed, honours flush.
module wiredleg_div_ctrl
  import wired0_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  state_e            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_sign;
  logic              r_sel;
  logic [TAG_W-1:0]  r_tag;

  op_e               w_op;
  logic              w_accept;
  logic              w_div_start;
  logic              w_div_busy;
  logic [DATA_W-1:0] w_quo;
  logic [DATA_W-1:0] w_rem;

  assign w_op     = op_e'(in_op);
  assign in_ready = (r_state == IDLE) && !flush && !rst;
  assign w_accept = in_valid && in_ready;
  // Start is decoded from the state so a flush in START can still suppress it.
  assign w_div_start = (r_state == START) && !flush;

  // NOTE: all state uses non-blocking assignments so every branch below sees the
  // pre-edge values, whatever order the case arms are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= 1'b0;
      r_sel     <= 1'b0;
      r_tag     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_sign <= op_is_signed(w_op);
            r_sel  <= op_is_rem(w_op);
            r_tag  <= in_tag;
            if (in_b == '0) begin
              out_data  <= op_is_rem(w_op) ? in_a : ALL_ONES;
              out_tag   <= in_tag;
              out_valid <= 1'b1;
              r_state   <= HOLD;
            end else begin
              r_state <= START;
            end
          end
        end
        START: r_state <= flush ? IDLE : WAIT;
        WAIT: begin
          if (flush) begin
            r_state <= DRAIN;
          end else if (!w_div_busy) begin
            out_data  <= r_sel ? w_rem : w_quo;
            out_tag   <= r_tag;
            out_valid <= 1'b1;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        DRAIN: if (!w_div_busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  wiredleg_div_fast u_div (
    .clk     (clk),
    .i_rst_n (~rst),
    .i_start (w_div_start),
    .i_sign  (r_sign),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_busy  (w_div_busy),
    .o_quo   (w_quo),
    .o_rem   (w_rem)
  );

endmodule

// File: tb/tb_wiredleg_div_ctrl.sv
// Self-checking bench for wiredleg_div_ctrl: vector table, random traffic through a
// scoreboard, and hand-written flush / hold / reset sequences.
module tb_wiredleg_div_ctrl;
  import wired0_pkg::*;

  localparam int TAG_W = 5;

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [1:0]       in_op = '0;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_start  = 0;
  bit   rand_on  = 1'b0;
  exp_t sb_q[$];
  vec_t vecs[15];

  wiredleg_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.w_div_start) n_start++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  // Scoreboard: compare every result handed downstream.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  // Returns just after the accepting edge (#1), or with ok=0 on timeout.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input bit push, output bit ok);
    bit got;
    exp_t e;
    @(posedge clk);
    #1;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    ok = got;
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.data = model(op, a, b);
      e.tag  = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_out_valid(input string name, output int lat);
    bit done = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        done = 1'b1;
      end
    end
    if (!done) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int lat, s0, low_cnt;
    bit bad;
    logic [31:0] d0;
    logic [TAG_W-1:0] t0;

    vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD};
    vecs[1]  = '{2'd1, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF};
    vecs[2]  = '{2'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'h7FFF_FFFF};
    vecs[3]  = '{2'd3, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'h0000_0001};
    vecs[4]  = '{2'd0, 32'd5,         32'd0,         5'd5,  32'hFFFF_FFFF};
    vecs[5]  = '{2'd1, 32'd5,         32'd0,         5'd6,  32'h0000_0005};
    vecs[6]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000};
    vecs[7]  = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000};
    vecs[8]  = '{2'd2, 32'd100,       32'd7,         5'd9,  32'd14};
    vecs[9]  = '{2'd3, 32'd100,       32'd7,         5'd10, 32'd2};
    vecs[10] = '{2'd0, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD};
    vecs[11] = '{2'd1, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1};
    vecs[12] = '{2'd2, 32'd0,         32'd0,         5'd13, 32'hFFFF_FFFF};
    vecs[13] = '{2'd3, 32'd0,         32'd0,         5'd14, 32'd0};
    vecs[14] = '{2'd0, 32'h1234_5678, 32'h10,        5'd31, 32'h0123_4567};

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_div_start", 32'(dut.w_div_start), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Table vectors, one at a time, with latency checks.
    foreach (vecs[i]) begin
      check("table_model", model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      s0 = n_start;
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, ok);
      if (ok) begin
        wait_out_valid("table_timeout", lat);
        if (vecs[i].b == 0) begin
          check("bypass_latency", 32'(lat), 32'd1);
          check("bypass_no_start", 32'(n_start - s0), 32'd0);
        end else begin
          check("div_latency_range", 32'(lat >= 5 && lat <= 19), 32'd1);
          check("div_one_start", 32'(n_start - s0), 32'd1);
        end
        wait_empty(50);
      end
    end

    // Flush two cycles into WAIT; no result, in_ready low while the divider drains.
    send(2'd2, 32'hFFFF_FFFF, 32'd3, 5'd17, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bad = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
      if (dut.w_div_busy && in_ready) bad = 1'b1;
      if (!in_ready) low_cnt++;
    end
    check("drain_clean", 32'(bad), 32'd0);
    check("drain_ready_back", 32'(in_ready), 32'd1);
    check("drain_held_ready_low", 32'(low_cnt >= 1), 32'd1);
    send(2'd2, 32'd100, 32'd7, 5'd22, 1'b1, ok);
    wait_empty(60);

    // Flush during START suppresses the divider start.
    s0 = n_start;
    send(2'd0, 32'd1000, 32'd3, 5'd3, 1'b0, ok);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    check("start_flush_no_pulse", 32'(n_start - s0), 32'd0);
    check("start_flush_no_out", 32'(bad), 32'd0);
    check("start_flush_idle", 32'(in_ready), 32'd1);

    // Back-pressure in HOLD: outputs frozen, no accept, then release.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(2'd2, 32'd100, 32'd7, 5'd9, 1'b1, ok);
    wait_out_valid("hold_timeout", lat);
    d0 = out_data;
    t0 = out_tag;
    check("hold_data", d0, 32'd14);
    repeat (10) begin
      @(negedge clk);
      check("hold_stable", 32'(out_valid && out_data == d0 && out_tag == t0 && !in_ready),
            32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_sb", 32'(sb_q.size()), 32'd0);

    // Flush in HOLD with out_ready high discards the result.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(2'd0, 32'd5, 32'd0, 5'd4, 1'b0, ok);
    @(negedge clk);
    check("hold_flush_pre", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 begin flush = 1'b1; out_ready = 1'b1; end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("hold_flush_drop", 32'(out_valid), 32'd0);
    check("hold_flush_idle", 32'(in_ready), 32'd1);

    // Reset mid-operation abandons the result.
    send(2'd0, 32'd1000, 32'd3, 5'd6, 1'b0, ok);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid || dut.w_div_busy) bad = 1'b1;
    end
    check("midrst_no_result", 32'(bad), 32'd0);

    // Random traffic with random back-pressure.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      send(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)), 1'b1, ok);
    end
    wait_empty(500);
    rand_on = 1'b0;
    repeat (3) @(posedge clk);

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wiredleg_div_ctrl.md
WIREDLEG_DIV_CTRL -- requirements
Module: wiredleg_div_ctrl

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of destination tag carried with each operation.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  upstream offers an operation.
REQ-005 SHALL have port: in_ready  output  1  block accepts the operation this cycle.
REQ-006 SHALL have port: in_op  input  2  0=DIV (signed quotient), 1=MOD (signed remainder), 2=DIVU, 3=MODU.
REQ-007 SHALL have port: in_a  input  32  dividend.
REQ-008 SHALL have port: in_b  input  32  divisor.
REQ-009 SHALL have port: in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have port: flush  input  1  cancel any in-flight or held operation.
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  downstream consumes the result.
REQ-013 SHALL have port: out_data  output  32  selected quotient or remainder.
REQ-014 SHALL have port: out_tag  output  TAG_W  tag of the result.

Function
REQ-015 SHALL use states IDLE, START, WAIT, HOLD, DRAIN.
REQ-016 SHALL drive in_ready = (state==IDLE) && !flush && !rst.
REQ-017 SHALL, on accept at cycle T, register a, b, op, tag; sign = !op[1]; select = op[0] (1 = remainder).
REQ-018 SHALL, if b==0 on accept, bypass the divider: go to HOLD at T+1 with out_data = 0xFFFFFFFF (quotient ops) or a (remainder ops).
REQ-019 SHALL otherwise go to START at T+1 and pulse divider start for exactly that one cycle with registered a, b, sign.
REQ-020 SHALL go START->WAIT at T+2 and ignore divider busy during START; busy only rises the cycle after start.
REQ-021 SHALL, in WAIT, on the first cycle busy==0, capture rem or quo per select into out_data, load out_tag, and enter HOLD next cycle.
REQ-022 SHALL hold out_valid=1 in HOLD with out_data and out_tag stable until out_ready=1, then return to IDLE. No same-cycle accept of a new operation.
REQ-023 SHALL apply flush with priority over every other event: IDLE stays IDLE; START goes to IDLE and suppresses start; WAIT goes to DRAIN; HOLD goes to IDLE and drops out_valid even if out_ready=1 in that cycle. The result is discarded.
REQ-024 SHALL stay in DRAIN until divider busy==0, then go to IDLE. A flush in DRAIN is a no-op.
REQ-025 SHALL not special-case signed overflow: 0x80000000 DIV 0xFFFFFFFF yields 0x80000000, MOD yields 0.
REQ-026 SHALL give non-zero-divisor latency from accept to out_valid of 3 + divider busy cycles (busy cycles 2..16).

Reset
REQ-027 SHALL on rst force state=IDLE, out_valid=0, out_data=0, out_tag=0, divider start=0 and in_ready=0, independent of clk.
REQ-028 SHALL drive the divider's active-low synchronous reset from ~rst. Reset mid-operation abandons the result with no output pulse.

Structure
REQ-029 SHALL take the op encoding enum (DIV, MOD, DIVU, MODU) and the state enum from the shared wired0 package.
REQ-030 SHALL instantiate exactly one sub-module, wiredleg_div_fast, as the arithmetic engine. All other logic is local.

Verification
REQ-031 SHALL check: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; MOD same operands -> 0xFFFFFFFF.
REQ-032 SHALL check: DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; MODU -> 0x00000001.
REQ-033 SHALL check: DIV a=5, b=0 accepted at T -> out_valid at T+1, data 0xFFFFFFFF; MOD a=5, b=0 -> 0x00000005. Divider start never pulses.
REQ-034 SHALL check: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; MOD -> 0x00000000.
REQ-035 SHALL check: flush two cycles into WAIT on DIVU 0xFFFFFFFF/3 -> no out_valid; in_ready low until busy falls. The next DIVU 100/7 returns 14 with the new tag.
REQ-036 SHALL check: out_ready held low 10 cycles in HOLD -> out_valid, out_data, out_tag constant and in_ready=0; release -> IDLE and in_ready=1 the following cycle.
